// File: rtl/alu_unit.sv
// ALU stage between the A/B operand registers and the shared system bus.
// Single-cycle ops finish in one clock; MUL is a Width-step shift-add sequence.
module alu_unit #(
   parameter int Width = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   inout  logic [Width-1:0] Bus,
   input  logic [Width-1:0] A,
   input  logic [Width-1:0] B,
   input  logic [3:0]       Op,
   input  logic             Start,
   input  logic             AluOut,
   output logic             Busy,
   output logic             Done,
   output logic [3:0]       Flags
);

   localparam int CntW = $clog2(Width) + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_INC = 4'd8;
   localparam logic [3:0] OP_DEC = 4'd9;
   localparam logic [3:0] OP_MUL = 4'd10;

   localparam logic [Width:0]     ONE_EXT  = 1;
   localparam logic [CntW-1:0]    CNT_LAST = CntW'(Width - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [Width-1:0]     result_q, result_d;
   logic [3:0]           flags_q, flags_d;
   logic                 done_q, done_d;
   logic [2*Width-1:0]   mcand_q, mcand_d;
   logic [Width-1:0]     mplier_q, mplier_d;
   logic [2*Width-1:0]   acc_q, acc_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   logic [Width:0]       sum_ext;
   logic [Width-1:0]     alu_res;
   logic                 alu_c;
   logic                 alu_v;
   logic [2*Width-1:0]   mul_acc_next;
   logic                 mul_last;

   // Single-cycle datapath; sum_ext carries the carry/borrow in its top bit.
   always_comb begin
      sum_ext = '0;
      alu_res = A;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (Op)
         OP_ADD: begin
            sum_ext = {1'b0, A} + {1'b0, B};
            alu_res = sum_ext[Width-1:0];
            alu_c   = sum_ext[Width];
            alu_v   = (A[Width-1] == B[Width-1]) && (alu_res[Width-1] != A[Width-1]);
         end
         OP_SUB: begin
            sum_ext = {1'b0, A} - {1'b0, B};
            alu_res = sum_ext[Width-1:0];
            alu_c   = sum_ext[Width];
            alu_v   = (A[Width-1] != B[Width-1]) && (alu_res[Width-1] != A[Width-1]);
         end
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_XOR: alu_res = A ^ B;
         OP_NOT: alu_res = ~A;
         OP_SHL: begin
            alu_res = {A[Width-2:0], 1'b0};
            alu_c   = A[Width-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, A[Width-1:1]};
            alu_c   = A[0];
         end
         OP_INC: begin
            sum_ext = {1'b0, A} + ONE_EXT;
            alu_res = sum_ext[Width-1:0];
            alu_c   = sum_ext[Width];
            alu_v   = ~A[Width-1] & alu_res[Width-1];
         end
         OP_DEC: begin
            sum_ext = {1'b0, A} - ONE_EXT;
            alu_res = sum_ext[Width-1:0];
            alu_c   = sum_ext[Width];
            alu_v   = A[Width-1] & ~alu_res[Width-1];
         end
         default: alu_res = A;
      endcase
   end

   assign mul_acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign mul_last     = (cnt_q == CNT_LAST);

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               if (Op == OP_MUL) begin
                  mcand_d  = {{Width{1'b0}}, A};
                  mplier_d = B;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else begin
                  result_d = alu_res;
                  flags_d  = {(alu_res == '0), alu_res[Width-1], alu_c, alu_v};
                  done_d   = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = mul_acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // Final step commits the just-computed accumulator, not acc_q.
            if (mul_last) begin
               result_d = mul_acc_next[Width-1:0];
               flags_d  = {(mul_acc_next[Width-1:0] == '0), mul_acc_next[Width-1],
                           (mul_acc_next[2*Width-1:Width] != '0), 1'b0};
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Busy  = (state_q == S_MUL);
   assign Done  = done_q;
   assign Flags = flags_q;
   assign Bus   = AluOut ? result_q : {Width{1'bz}};

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit; the bench itself drives a marker pattern
// onto the bus whenever it needs to confirm the ALU has released it.
module tb_alu_unit;

   logic        Clk;
   logic        Rst_n;
   wire  [15:0] bus_w;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  Op;
   logic        Start;
   logic        AluOut;
   logic        Busy;
   logic        Done;
   logic [3:0]  Flags;
   logic        tb_drv;

   int vec_cnt = 0;
   int err_cnt = 0;

   localparam logic [15:0] MARK = 16'h5A5A;

   assign bus_w = tb_drv ? MARK : 16'hzzzz;

   alu_unit #(.Width(16)) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Bus    (bus_w),
      .A      (A),
      .B      (B),
      .Op     (Op),
      .Start  (Start),
      .AluOut (AluOut),
      .Busy   (Busy),
      .Done   (Done),
      .Flags  (Flags)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res,
                        input logic [3:0] exp_flags);
      A = a; B = b; Op = op; Start = 1'b1;
      tick();
      Start = 1'b0;
      check({name, " done"},  32'(Done),  32'd1);
      check({name, " busy"},  32'(Busy),  32'd0);
      check({name, " result"}, 32'(bus_w), 32'(exp_res));
      check({name, " flags"}, 32'(Flags), 32'(exp_flags));
      $display("op %-6s A=%h B=%h -> result=%h flags=%b", name, a, b, bus_w, Flags);
   endtask

   task automatic mul_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] prev, input logic [15:0] exp_res,
                         input logic [3:0] exp_flags, input bit disturb);
      A = a; B = b; Op = 4'd10; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check({name, " busy run"}, 32'(Busy), 32'd1);
         check({name, " done run"}, 32'(Done), 32'd0);
         check({name, " bus run"},  32'(bus_w), 32'(prev));
         if (disturb && i == 4) begin
            A = 16'hFFFF; B = 16'hFFFF; Op = 4'd10; Start = 1'b1;
         end
         if (disturb && i == 5) Start = 1'b0;
         tick();
      end
      check({name, " done"},   32'(Done),  32'd1);
      check({name, " busy end"}, 32'(Busy), 32'd0);
      check({name, " result"}, 32'(bus_w), 32'(exp_res));
      check({name, " flags"},  32'(Flags), 32'(exp_flags));
      $display("op %-6s A=%h B=%h -> result=%h flags=%b", name, a, b, bus_w, Flags);
      tick();
      check({name, " done drop"}, 32'(Done), 32'd0);
      check({name, " idle"},      32'(Busy), 32'd0);
      check({name, " hold"},      32'(bus_w), 32'(exp_res));
   endtask

   initial begin
      Rst_n = 1'b0; AluOut = 1'b1; Start = 1'b0; tb_drv = 1'b0;
      A = '0; B = '0; Op = '0;
      tick();
      tick();
      check("rst bus",   32'(bus_w), 32'h0000);
      check("rst flags", 32'(Flags), 32'h0);
      check("rst busy",  32'(Busy),  32'd0);
      check("rst done",  32'(Done),  32'd0);
      AluOut = 1'b0; tb_drv = 1'b1;
      #1;
      check("rst bus release", 32'(bus_w), 32'(MARK));
      tb_drv = 1'b0; AluOut = 1'b1;
      $display("reset applied");
      Rst_n = 1'b1;

      // Back-to-back single-cycle ops, one Start per clock.
      do_op("ADDV",  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
      do_op("ADDC",  4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010);
      do_op("SUBB",  4'd1,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
      do_op("SUBV",  4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001);
      do_op("SHL",   4'd6,  16'h8001, 16'h0000, 16'h0002, 4'b0010);
      do_op("SHR",   4'd7,  16'h0001, 16'h0000, 16'h0000, 4'b1010);
      do_op("AND",   4'd2,  16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
      do_op("OR",    4'd3,  16'h0F0F, 16'h00F0, 16'h0FFF, 4'b0000);
      do_op("XOR",   4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000);
      do_op("NOT",   4'd5,  16'h0000, 16'h1234, 16'hFFFF, 4'b0100);
      do_op("INCV",  4'd8,  16'h7FFF, 16'h0000, 16'h8000, 4'b0101);
      do_op("INCC",  4'd8,  16'hFFFF, 16'h0000, 16'h0000, 4'b1010);
      do_op("DECB",  4'd9,  16'h0000, 16'h0000, 16'hFFFF, 4'b0110);
      do_op("DECV",  4'd9,  16'h8000, 16'h0000, 16'h7FFF, 4'b0001);
      do_op("PASS",  4'd15, 16'h1234, 16'hFFFF, 16'h1234, 4'b0000);
      do_op("PASSN", 4'd11, 16'hABCD, 16'h0000, 16'hABCD, 4'b0100);

      tick();
      check("idle done",  32'(Done),  32'd0);
      check("idle flags", 32'(Flags), 32'b0100);
      check("idle hold",  32'(bus_w), 32'hABCD);

      mul_op("MUL1", 16'h0123, 16'h0010, 16'hABCD, 16'h1230, 4'b0000, 1'b1);
      mul_op("MUL2", 16'h1000, 16'h0010, 16'h1230, 16'h0000, 4'b1010, 1'b0);

      AluOut = 1'b0; tb_drv = 1'b1;
      #1;
      check("bus release", 32'(bus_w), 32'(MARK));
      tb_drv = 1'b0; AluOut = 1'b1;

      // Abort a MUL partway through with reset.
      A = 16'h0003; B = 16'h0005; Op = 4'd10; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("abort busy pre", 32'(Busy), 32'd1);
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      check("abort busy",  32'(Busy),  32'd0);
      check("abort done",  32'(Done),  32'd0);
      check("abort bus",   32'(bus_w), 32'h0000);
      check("abort flags", 32'(Flags), 32'h0);
      $display("reset during MUL applied");
      do_op("ADDR", 4'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
      tick();
      check("post done", 32'(Done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
